rpn_stack_ctrl: RTL and testbench

- Reverse-Polish token engine that sits upstream of the 8-entry byte LIFO and drives its push/pop ports.
- Also sits downstream of it, consuming popped data.
- Accepts a valid/ready token stream: operands are pushed; operators pop two entries, compute, and push the result.
- Keeps its own depth mirror, flags stack errors, and reports each computed result.

---
 rtl/rpn_pkg.sv | 32 +++
 rtl/rpn_alu.sv | 30 +++
 rtl/rpn_stack_ctrl.sv | 137 +++++++++++++
 tb/tb_rpn_stack_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// Purpose: shared opcodes, FSM state encoding and size defaults for the RPN stack controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rpn_pkg;

    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 8;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_AND    = 3'b010;
    localparam logic [2:0] OP_OR     = 3'b011;
    localparam logic [2:0] OP_XOR    = 3'b100;
    localparam logic [2:0] OP_MUL    = 3'b101;
    // 110 and 111 are reserved and never reach the LIFO
    localparam logic [2:0] OP_RSV_LO = 3'b110;
    localparam logic [2:0] OP_RSV_HI = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PUSH_OP  = 3'd1,
        S_POP_B    = 3'd2,
        S_POP_A    = 3'd3,
        S_CAPT     = 3'd4,
        S_PUSH_RES = 3'd5
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op < OP_RSV_LO);
    endfunction

endpackage

// File: rtl/rpn_alu.sv
// Purpose: combinational f(a,b,op) for the RPN engine, modulo 2^DW, no carry out.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; ports a_i/b_i/op_i in, y_o out.
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] a_i,   // deeper entry
    input  logic [DW-1:0] b_i,   // top entry
    input  logic [2:0]    op_i,
    output logic [DW-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_ADD:    y_o = a_i + b_i;
            OP_SUB:    y_o = a_i - b_i;
            OP_AND:    y_o = a_i & b_i;
            OP_OR:     y_o = a_i | b_i;
            OP_XOR:    y_o = a_i ^ b_i;
            OP_MUL:    y_o = a_i * b_i;   // DW-bit context keeps only the low product bits
            OP_RSV_LO,
            OP_RSV_HI: y_o = '0;
            default:   y_o = '0;
        endcase
    end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// Purpose: RPN token engine driving an external byte LIFO; pushes operands, pops two/pushes one per operator.
// Latency: operand accept->next ready 2 cycles; operator accept->lifo_wn 4, ->next ready 5 cycles.
// Backpressure: tok_ready only in IDLE and out of reset; ports: token stream in, LIFO strobes out, result/depth/sticky errors out.
module rpn_stack_ctrl
    import rpn_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    parameter  int DW    = DW_DEF,
    localparam int DPW   = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tok_valid,
    output logic           tok_ready,
    input  logic           tok_is_op,
    input  logic [DW-1:0]  tok_data,
    output logic           lifo_wn,
    output logic           lifo_rn,
    output logic [DW-1:0]  lifo_datain,
    input  logic [DW-1:0]  lifo_dataout,
    input  logic           lifo_full,
    input  logic           lifo_empty,
    output logic           result_valid,
    output logic [DW-1:0]  result,
    output logic [DPW-1:0] depth,
    input  logic           clr_err,
    output logic           err_overflow,
    output logic           err_underflow,
    output logic           err_illegal,
    output logic           err_sync
);

    localparam logic [DPW-1:0] FULL_CNT = DPW'(DEPTH);

    state_t         state_q;
    logic [DPW-1:0] depth_q;
    logic [2:0]     op_q;
    logic [DW-1:0]  b_q;
    logic [DW-1:0]  alu_y;

    assign tok_ready = (state_q == S_IDLE) && !reset;
    assign depth     = depth_q;

    // In CAPT the LIFO presents operand a, so it feeds the ALU directly
    // and the result is registered straight into lifo_datain/result.
    rpn_alu #(.DW(DW)) u_alu (
        .a_i  (lifo_dataout),
        .b_i  (b_q),
        .op_i (op_q),
        .y_o  (alu_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            depth_q       <= '0;
            op_q          <= '0;
            b_q           <= '0;
            lifo_wn       <= 1'b0;
            lifo_rn       <= 1'b0;
            lifo_datain   <= '0;
            result_valid  <= 1'b0;
            result        <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            err_illegal   <= 1'b0;
            err_sync      <= 1'b0;
        end else begin
            lifo_wn      <= 1'b0;
            lifo_rn      <= 1'b0;
            result_valid <= 1'b0;

            // Clear first; any set below in the same cycle wins.
            if (clr_err) begin
                err_overflow  <= 1'b0;
                err_underflow <= 1'b0;
                err_illegal   <= 1'b0;
                err_sync      <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    // Mirror and LIFO flags only settle together in IDLE.
                    if ((lifo_full != (depth_q == FULL_CNT)) ||
                        (lifo_empty != (depth_q == '0)))
                        err_sync <= 1'b1;

                    if (tok_valid) begin
                        if (!tok_is_op) begin
                            if (depth_q == FULL_CNT) begin
                                err_overflow <= 1'b1;
                            end else begin
                                lifo_wn     <= 1'b1;
                                lifo_datain <= tok_data;
                                state_q     <= S_PUSH_OP;
                            end
                        end else if (!op_is_legal(tok_data[2:0])) begin
                            err_illegal <= 1'b1;
                        end else if (depth_q < DPW'(2)) begin
                            err_underflow <= 1'b1;
                        end else begin
                            op_q    <= tok_data[2:0];
                            lifo_rn <= 1'b1;
                            state_q <= S_POP_B;
                        end
                    end
                end
                S_PUSH_OP: begin
                    depth_q <= depth_q + 1'b1;
                    state_q <= S_IDLE;
                end
                S_POP_B: begin
                    lifo_rn <= 1'b1;
                    state_q <= S_POP_A;
                end
                S_POP_A: begin
                    b_q     <= lifo_dataout;   // data from the first pop
                    state_q <= S_CAPT;
                end
                S_CAPT: begin
                    lifo_wn      <= 1'b1;
                    lifo_datain  <= alu_y;
                    result       <= alu_y;
                    result_valid <= 1'b1;
                    state_q      <= S_PUSH_RES;
                end
                S_PUSH_RES: begin
                    // Net effect of pop, pop, push.
                    depth_q <= depth_q - 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Purpose: directed self-checking bench for rpn_stack_ctrl with a behavioural 8-entry LIFO attached.
// Latency: checks operand/operator timing relative to the accept edge.
// Backpressure: tokens are offered only after tok_ready is seen high.
module tb_rpn_stack_ctrl;

    logic       clk;
    logic       reset;
    logic       tok_valid;
    logic       tok_ready;
    logic       tok_is_op;
    logic [7:0] tok_data;
    logic       lifo_wn;
    logic       lifo_rn;
    logic [7:0] lifo_datain;
    logic [7:0] lifo_dataout;
    logic       lifo_full;
    logic       lifo_empty;
    logic       result_valid;
    logic [7:0] result;
    logic [3:0] depth;
    logic       clr_err;
    logic       err_overflow;
    logic       err_underflow;
    logic       err_illegal;
    logic       err_sync;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural LIFO and strobe monitors
    logic [7:0] mem [8];
    int  lcnt     = 0;
    int  wn_cnt   = 0;
    int  rn_cnt   = 0;
    int  both_cnt = 0;
    logic full_low = 1'b0;

    assign lifo_full  = (lcnt == 8) && !full_low;
    assign lifo_empty = (lcnt == 0);

    rpn_stack_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .tok_valid     (tok_valid),
        .tok_ready     (tok_ready),
        .tok_is_op     (tok_is_op),
        .tok_data      (tok_data),
        .lifo_wn       (lifo_wn),
        .lifo_rn       (lifo_rn),
        .lifo_datain   (lifo_datain),
        .lifo_dataout  (lifo_dataout),
        .lifo_full     (lifo_full),
        .lifo_empty    (lifo_empty),
        .result_valid  (result_valid),
        .result        (result),
        .depth         (depth),
        .clr_err       (clr_err),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .err_illegal   (err_illegal),
        .err_sync      (err_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) begin
            lcnt <= 0;
        end else begin
            if (lifo_wn) wn_cnt <= wn_cnt + 1;
            if (lifo_rn) rn_cnt <= rn_cnt + 1;
            if (lifo_wn && lifo_rn) both_cnt <= both_cnt + 1;
            if (lifo_wn && lcnt < 8) begin
                mem[3'(lcnt)] <= lifo_datain;
                lcnt <= lcnt + 1;
            end else if (lifo_rn && lcnt > 0) begin
                lifo_dataout <= mem[3'(lcnt - 1)];
                lcnt <= lcnt - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (tok_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 32'(tok_ready), 32'd1);
    endtask

    task automatic push(input logic [7:0] v);
        wait_ready("push_ready");
        tok_valid = 1'b1;
        tok_is_op = 1'b0;
        tok_data  = v;
        tick();
        tok_valid = 1'b0;
        tok_data  = 8'($urandom);
        wait_ready("push_done");
    endtask

    task automatic issue_op(input logic [2:0] code);
        wait_ready("op_ready");
        tok_valid = 1'b1;
        tok_is_op = 1'b1;
        tok_data  = {5'($urandom), code};
        tick();
        tok_valid = 1'b0;
        tok_data  = 8'($urandom);
    endtask

    // Legal operator: four cycles after accept the result push is on the LIFO port,
    // one more cycle and tok_ready is back.
    task automatic do_op(input string tag, input logic [2:0] code, input logic [7:0] exp);
        int r0;
        r0 = rn_cnt;
        issue_op(code);
        chk({tag, "_popb_rn"}, 32'(lifo_rn), 32'd1);
        repeat (3) tick();
        chk({tag, "_wn"},     32'(lifo_wn),      32'd1);
        chk({tag, "_datain"}, 32'(lifo_datain),  32'(exp));
        chk({tag, "_rv"},     32'(result_valid), 32'd1);
        chk({tag, "_result"}, 32'(result),       32'(exp));
        chk({tag, "_rn2"},    32'(rn_cnt - r0),  32'd2);
        tick();
        chk({tag, "_ready"},  32'(tok_ready),    32'd1);
        chk({tag, "_rv_off"}, 32'(result_valid), 32'd0);
    endtask

    initial begin
        int w0;
        int r0;
        reset     = 1'b1;
        tok_valid = 1'b0;
        tok_is_op = 1'b0;
        tok_data  = 8'h00;
        clr_err   = 1'b0;
        repeat (3) tick();
        chk("ready_in_reset", 32'(tok_ready), 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_strobes", {30'd0, lifo_wn, lifo_rn}, 32'd0);
        chk("rst_result", {23'd0, result_valid, result}, 32'd0);
        chk("rst_errs", {28'd0, err_overflow, err_underflow, err_illegal, err_sync}, 32'd0);
        chk("rst_ready", 32'(tok_ready), 32'd1);

        // 3 + 4 = 7
        push(8'h03);
        push(8'h04);
        chk("depth_2", 32'(depth), 32'd2);
        do_op("add", 3'b000, 8'h07);
        chk("add_depth", 32'(depth), 32'd1);

        // 2 - 5 = 0xFD, 0x10 * 0x20 = 0x200 -> 0x00
        push(8'h02);
        push(8'h05);
        do_op("sub", 3'b001, 8'hFD);
        push(8'h10);
        push(8'h20);
        do_op("mul", 3'b101, 8'h00);
        chk("mul_depth", 32'(depth), 32'd3);
        chk("no_sync_err", 32'(err_sync), 32'd0);

        // Underflow: one entry, ADD dropped
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push(8'h01);
        r0 = rn_cnt;
        issue_op(3'b000);
        chk("uf_flag", 32'(err_underflow), 32'd1);
        chk("uf_rn", 32'(lifo_rn), 32'd0);
        chk("uf_ready", 32'(tok_ready), 32'd1);
        chk("uf_depth", 32'(depth), 32'd1);
        tick();
        chk("uf_no_pops", 32'(rn_cnt - r0), 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("uf_clr", 32'(err_underflow), 32'd0);
        chk("uf_clr_depth", 32'(depth), 32'd1);

        // Overflow: 9 pushes, 8 land
        reset = 1'b1;
        tick();
        reset = 1'b0;
        w0 = wn_cnt;
        for (int i = 0; i < 9; i++) push(8'(i + 8'h30));
        chk("of_wn_count", 32'(wn_cnt - w0), 32'd8);
        chk("of_flag", 32'(err_overflow), 32'd1);
        chk("of_depth", 32'(depth), 32'd8);
        chk("of_no_sync", 32'(err_sync), 32'd0);
        full_low = 1'b1;
        tick();
        tick();
        chk("sync_flag", 32'(err_sync), 32'd1);
        full_low = 1'b0;

        // Reserved opcode, then OR
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("rst_clears_errs", {28'd0, err_overflow, err_underflow, err_illegal, err_sync}, 32'd0);
        push(8'hF0);
        push(8'h0F);
        w0 = wn_cnt;
        r0 = rn_cnt;
        issue_op(3'b110);
        chk("ill_flag", 32'(err_illegal), 32'd1);
        chk("ill_ready", 32'(tok_ready), 32'd1);
        tick();
        chk("ill_no_strobes", 32'((wn_cnt - w0) + (rn_cnt - r0)), 32'd0);
        chk("ill_depth", 32'(depth), 32'd2);
        do_op("or", 3'b011, 8'hFF);
        chk("or_depth", 32'(depth), 32'd1);

        // Reset during POP_A aborts the operator
        push(8'h05);
        push(8'h06);
        issue_op(3'b000);
        tick();
        chk("popa_rn", 32'(lifo_rn), 32'd1);
        reset = 1'b1;
        tick();
        chk("abort_strobes", {30'd0, lifo_wn, lifo_rn}, 32'd0);
        chk("abort_depth", 32'(depth), 32'd0);
        chk("abort_errs", {28'd0, err_overflow, err_underflow, err_illegal, err_sync}, 32'd0);
        chk("abort_ready", 32'(tok_ready), 32'd0);
        reset = 1'b0;
        tick();
        push(8'h01);
        push(8'h02);
        do_op("post_rst_add", 3'b000, 8'h03);
        chk("post_rst_depth", 32'(depth), 32'd1);
        chk("post_rst_sync", 32'(err_sync), 32'd0);
        chk("never_both_strobes", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
